// File: rtl/sram_mem_ctrl_pkg.sv
// Shared widths and port-FSM state encodings for the dual-port SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH = 9;
  localparam int unsigned SRAM_DATA_WIDTH = 32;
  localparam int unsigned SRAM_NUM_WMASKS = SRAM_DATA_WIDTH / 8;

  localparam int unsigned ST_WIDTH = 3;

  // Port FSM states; STALL is used only by the read port on a write collision.
  localparam logic [ST_WIDTH-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_WIDTH-1:0] ST_ACCESS  = 3'd1;
  localparam logic [ST_WIDTH-1:0] ST_CAPTURE = 3'd2;
  localparam logic [ST_WIDTH-1:0] ST_DONE    = 3'd3;
  localparam logic [ST_WIDTH-1:0] ST_STALL   = 3'd4;

  function automatic logic is_write(input logic [SRAM_NUM_WMASKS-1:0] wstrb);
    return |wstrb;
  endfunction

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// CPU native bus plus secondary read-only requester, grouped for the controller.
interface sram_cpu_if
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH
);
  logic                       mem_valid;
  logic [31:0]                mem_addr;
  logic [SRAM_DATA_WIDTH-1:0] mem_wdata;
  logic [SRAM_NUM_WMASKS-1:0] mem_wstrb;
  logic                       mem_ready;
  logic [SRAM_DATA_WIDTH-1:0] mem_rdata;

  logic                       rd_valid;
  logic [ADDR_WIDTH-1:0]      rd_addr;
  logic                       rd_ready;
  logic [SRAM_DATA_WIDTH-1:0] rd_data;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb, rd_valid, rd_addr,
    input  mem_ready, mem_rdata, rd_ready, rd_data
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb, rd_valid, rd_addr,
    output mem_ready, mem_rdata, rd_ready, rd_data
  );
endinterface

// File: rtl/sram_mem_ctrl_rd_port.sv
// Read-only SRAM port FSM; defers its access one cycle when stalled by a same-word write.
module sram_rd_port
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       stall,
  input  logic                       rd_valid,
  input  logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic                       rd_ready,
  output logic [SRAM_DATA_WIDTH-1:0] rd_data,
  output logic                       csb1,
  output logic [ADDR_WIDTH-1:0]      addr1,
  input  logic [SRAM_DATA_WIDTH-1:0] dout1
);

  logic [ST_WIDTH-1:0]        state, state_nxt;
  logic                       csb1_nxt, ready_nxt;
  logic [ADDR_WIDTH-1:0]      addr1_nxt;
  logic [SRAM_DATA_WIDTH-1:0] data_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      csb1     <= 1'b1;
      addr1    <= '0;
      rd_ready <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      csb1     <= csb1_nxt;
      addr1    <= addr1_nxt;
      rd_ready <= ready_nxt;
      rd_data  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    csb1_nxt  = 1'b1;
    ready_nxt = 1'b0;
    addr1_nxt = addr1;
    data_nxt  = rd_data;
    case (state)
      ST_IDLE: begin
        if (rd_valid) begin
          addr1_nxt = rd_addr;
          if (stall) begin
            state_nxt = ST_STALL;
          end else begin
            state_nxt = ST_ACCESS;
            csb1_nxt  = 1'b0;
          end
        end
      end
      ST_STALL: begin
        state_nxt = ST_ACCESS;
        csb1_nxt  = 1'b0;
      end
      ST_ACCESS: state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        data_nxt  = dout1;
        ready_nxt = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/sram_mem_ctrl.sv
// CPU-bus to dual-port SRAM bridge: RW port 0 serves the CPU, R port 1 the secondary reader.
module sram_mem_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       resetn,
  sram_cpu_if.slave                  bus,
  output logic                       clk0,
  output logic                       csb0,
  output logic                       web0,
  output logic [SRAM_NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0]      addr0,
  output logic [SRAM_DATA_WIDTH-1:0] din0,
  input  logic [SRAM_DATA_WIDTH-1:0] dout0,
  output logic                       clk1,
  output logic                       csb1,
  output logic [ADDR_WIDTH-1:0]      addr1,
  input  logic [SRAM_DATA_WIDTH-1:0] dout1
);

  localparam int unsigned SEL_LSB = ADDR_WIDTH + 2;

  assign clk0 = clk;
  assign clk1 = clk;

  logic [ST_WIDTH-1:0]        state, state_nxt;
  logic                       csb0_nxt, web0_nxt, ready_nxt;
  logic [SRAM_NUM_WMASKS-1:0] wmask0_nxt;
  logic [ADDR_WIDTH-1:0]      addr0_nxt;
  logic [SRAM_DATA_WIDTH-1:0] din0_nxt, rdata_nxt;

  logic                  sel_c, accept_wr_c, stall_c;
  logic [ADDR_WIDTH-1:0] word_c;

  // Window decode on the bits above the SRAM byte range.
  assign sel_c       = bus.mem_valid && ((bus.mem_addr >> SEL_LSB) == (BASE_ADDR >> SEL_LSB));
  assign word_c      = bus.mem_addr[ADDR_WIDTH+1:2];
  assign accept_wr_c = (state == ST_IDLE) && sel_c && is_write(bus.mem_wstrb);
  assign stall_c     = accept_wr_c && (word_c == bus.rd_addr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      csb0          <= 1'b1;
      web0          <= 1'b1;
      wmask0        <= '0;
      addr0         <= '0;
      din0          <= '0;
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      state         <= state_nxt;
      csb0          <= csb0_nxt;
      web0          <= web0_nxt;
      wmask0        <= wmask0_nxt;
      addr0         <= addr0_nxt;
      din0          <= din0_nxt;
      bus.mem_ready <= ready_nxt;
      bus.mem_rdata <= rdata_nxt;
    end
  end

  // web0 still holds the accepted direction while in ACCESS.
  always_comb begin
    state_nxt  = state;
    csb0_nxt   = 1'b1;
    web0_nxt   = 1'b1;
    ready_nxt  = 1'b0;
    wmask0_nxt = wmask0;
    addr0_nxt  = addr0;
    din0_nxt   = din0;
    rdata_nxt  = bus.mem_rdata;
    case (state)
      ST_IDLE: begin
        if (sel_c) begin
          state_nxt  = ST_ACCESS;
          csb0_nxt   = 1'b0;
          web0_nxt   = ~is_write(bus.mem_wstrb);
          wmask0_nxt = bus.mem_wstrb;
          addr0_nxt  = word_c;
          din0_nxt   = bus.mem_wdata;
        end
      end
      ST_ACCESS: begin
        if (!web0) begin
          state_nxt = ST_DONE;
          ready_nxt = 1'b1;
        end else begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        rdata_nxt = dout0;
        ready_nxt = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  sram_rd_port #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rd_port (
    .clk     (clk),
    .resetn  (resetn),
    .stall   (stall_c),
    .rd_valid(bus.rd_valid),
    .rd_addr (bus.rd_addr),
    .rd_ready(bus.rd_ready),
    .rd_data (bus.rd_data),
    .csb1    (csb1),
    .addr1   (addr1),
    .dout1   (dout1)
  );

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Randomized bench for sram_mem_ctrl against an array-based memory reference and SRAM model.
`timescale 1ns/1ps
module tb_sram_mem_ctrl;
  import sram_ctrl_pkg::*;

  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h2000_0000;

  logic clk = 1'b0;
  logic resetn;
  logic clk0, csb0, web0, clk1, csb1;
  logic [3:0]    wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   din0, dout0, dout1;

  sram_cpu_if #(.ADDR_WIDTH(AW)) bus ();

  sram_mem_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .clk0(clk0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0),
    .clk1(clk1), .csb1(csb1), .addr1(addr1), .dout1(dout1)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM macro; a same-edge write/read of one word yields a poison value.
  logic [31:0] sram [DEPTH];
  always @(posedge clk) begin
    if (!csb1) dout1 <= (!csb0 && !web0 && addr0 == addr1) ? 32'hBAD0_BAD0 : sram[addr1];
    if (!csb0) begin
      if (web0) dout0 <= sram[addr0];
      else for (int b = 0; b < 4; b++) if (wmask0[b]) sram[addr0][8*b +: 8] = din0[8*b +: 8];
    end
  end

  logic [31:0] refm [DEPTH];
  logic [31:0] last_rd;
  int total = 0;
  int bad   = 0;

  logic          p0_csb, p0_web;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0]   p0_din, p0_rdata, p1_data;
  logic [3:0]    p0_wmask;
  logic [1:0]    p0_after;
  logic          p1_csb, p1_after;
  int            p0_acc, p1_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, ".csb"},   32'({csb0, csb1, web0}), 32'h7);
    chk({tag, ".p0"},    32'({wmask0, addr0}), 32'h0);
    chk({tag, ".din0"},  din0, 32'h0);
    chk({tag, ".addr1"}, 32'(addr1), 32'h0);
    chk({tag, ".rdy"},   32'({bus.mem_ready, bus.rd_ready}), 32'h0);
    chk({tag, ".rdata"}, bus.mem_rdata, 32'h0);
    chk({tag, ".rddat"}, bus.rd_data, 32'h0);
  endtask

  // CPU request from a negedge; returns cycles from acceptance to mem_ready (0 = timeout).
  task automatic cpu_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit hold, output int lat);
    bus.mem_valid = 1'b1; bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wstrb = s;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      bus.mem_valid = 1'b0; bus.mem_addr = $urandom; bus.mem_wdata = $urandom;
      bus.mem_wstrb = 4'($urandom);
    end
    p0_csb = csb0; p0_web = web0; p0_addr = addr0; p0_din = din0; p0_wmask = wmask0;
    p0_acc = 0; p0_rdata = 'x; lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (!csb0) p0_acc++;
      if (bus.mem_ready) begin lat = c; p0_rdata = bus.mem_rdata; end
    end
    @(negedge clk);
    p0_after = {bus.mem_ready, csb0};
    bus.mem_valid = 1'b0;
  endtask

  task automatic rd_op(input logic [AW-1:0] a, output int lat);
    bus.rd_valid = 1'b1; bus.rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    bus.rd_valid = 1'b0; bus.rd_addr = AW'($urandom);
    p1_acc = 0; p1_csb = 1'b1; p1_addr = 'x; p1_data = 'x; lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (!csb1) begin p1_acc++; p1_addr = addr1; p1_csb = 1'b0; end
      if (bus.rd_ready) begin lat = c; p1_data = bus.rd_data; end
    end
    @(negedge clk);
    p1_after = bus.rd_ready;
  endtask

  // One CPU and/or secondary transaction, both accepted on the same edge when both enabled.
  task automatic txn(input string tag, input bit cpu_en, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input bit hold,
                     input bit rd_en, input logic [AW-1:0] ra);
    int l0, l1;
    logic [AW-1:0] w;
    logic [31:0] exp0, exp1;
    bit wr, coll;
    l0 = 0; l1 = 0;
    w    = a[AW+1:2];
    wr   = (s != 4'h0);
    coll = cpu_en && rd_en && wr && (w == ra);
    exp1 = coll ? merge(refm[ra], d, s) : refm[ra];
    exp0 = wr ? last_rd : refm[w];
    if (cpu_en && wr) refm[w] = merge(refm[w], d, s);
    fork
      if (cpu_en) cpu_op(a, d, s, hold, l0);
      if (rd_en)  rd_op(ra, l1);
    join
    if (cpu_en) begin
      chk({tag, ".lat0"},  32'(l0), wr ? 32'd2 : 32'd3);
      chk({tag, ".acc0"},  32'(p0_acc), 32'd1);
      chk({tag, ".cyc1"},  32'({p0_csb, p0_web}), wr ? 32'h0 : 32'h1);
      chk({tag, ".addr0"}, 32'(p0_addr), 32'(w));
      if (wr) chk({tag, ".wr0"}, {p0_din[27:0], p0_wmask}, {d[27:0], s});
      chk({tag, ".rdata"}, p0_rdata, exp0);
      chk({tag, ".after0"}, 32'(p0_after), 32'h1);
      if (!wr) last_rd = exp0;
    end
    if (rd_en) begin
      chk({tag, ".lat1"},  32'(l1), coll ? 32'd4 : 32'd3);
      chk({tag, ".acc1"},  32'({p1_acc[7:0], 7'd0, p1_csb}), 32'h100);
      chk({tag, ".addr1"}, 32'(p1_addr), 32'(ra));
      chk({tag, ".rddat"}, p1_data, exp1);
      chk({tag, ".after1"}, 32'(p1_after), 32'h0);
    end
  endtask

  initial begin
    int n_acc, n_rdy, n_rrdy;
    logic [31:0] v;
    resetn = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0;
    last_rd = 32'h0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = $urandom;
      sram[i] = v;
      refm[i] = v;
    end
    repeat (3) @(negedge clk);
    chk_reset("por");
    resetn = 1'b1;

    // Directed: full write, readback, byte lane merge, collisions, shared reads.
    txn("wr_dead", 1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, '0);
    txn("rd_dead", 1, BASE + 32'h10, 32'h0, 4'h0, 0, 0, '0);
    chk("rd_dead.lit", p0_rdata, 32'hDEADBEEF);
    txn("wr_byte", 1, BASE + 32'h12, 32'h00AA0000, 4'b0100, 0, 0, '0);
    txn("rd_byte", 1, BASE + 32'h10, 32'h0, 4'h0, 1, 0, '0);
    chk("rd_byte.lit", p0_rdata, 32'hDEAABEEF);
    txn("coll7", 1, BASE + 32'h1C, 32'h1234_5678, 4'hF, 0, 1, AW'(7));
    chk("coll7.lit", p1_data, 32'h1234_5678);
    txn("share3", 1, BASE + 32'hC, 32'h0, 4'h0, 0, 1, AW'(3));
    chk("share3.same", p1_data, p0_rdata);
    txn("wr_hold", 1, BASE + 32'h7FC, 32'hCAFE_F00D, 4'hF, 1, 0, '0);

    // Requests outside the window must never touch the SRAM.
    for (int k = 0; k < 2; k++) begin
      bus.mem_valid = 1'b1; bus.mem_wstrb = 4'hF;
      bus.mem_addr = (k == 0) ? BASE + 32'h800 : BASE - 32'h4;
      n_acc = 0; n_rdy = 0;
      repeat (10) begin
        @(negedge clk);
        if (!csb0) n_acc++;
        if (bus.mem_ready) n_rdy++;
      end
      bus.mem_valid = 1'b0;
      chk("outside.acc", 32'(n_acc), 32'd0);
      chk("outside.rdy", 32'(n_rdy), 32'd0);
    end

    @(posedge clk); #1;
    chk("clk_hi", 32'({clk0, clk1}), 32'({clk, clk}));
    @(negedge clk); #1;
    chk("clk_lo", 32'({clk0, clk1}), 32'({clk, clk}));
    @(negedge clk);

    // Reset in CAPTURE aborts both ports with no late ready pulse.
    bus.mem_valid = 1'b1; bus.mem_addr = BASE + 32'h10; bus.mem_wstrb = 4'h0;
    bus.rd_valid = 1'b1; bus.rd_addr = AW'(4);
    @(posedge clk);
    @(negedge clk);
    bus.mem_valid = 1'b0; bus.rd_valid = 1'b0;
    @(negedge clk);
    #1 resetn = 1'b0;
    #1 chk_reset("rst_mid");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    last_rd = 32'h0;
    n_rdy = 0; n_rrdy = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.mem_ready) n_rdy++;
      if (bus.rd_ready) n_rrdy++;
    end
    chk("rst_mid.noready", 32'({n_rdy[15:0], n_rrdy[15:0]}), 32'h0);
    txn("post_rst", 1, BASE + 32'h10, 32'h0, 4'h0, 0, 1, AW'(4));

    // Randomized mix biased towards a few words so collisions occur.
    for (int i = 0; i < 80; i++) begin
      logic [AW-1:0] w, rw;
      logic [3:0] s;
      int kind;
      w    = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) w = AW'($urandom);
      rw   = ($urandom_range(0, 1) == 1) ? w : AW'($urandom_range(0, 15));
      s    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
      kind = $urandom_range(0, 2);
      txn("rnd", kind != 1, BASE + {21'd0, w, 2'b00} + 32'($urandom_range(0, 3)),
          $urandom, s, $urandom_range(0, 3) == 0, kind != 0, rw);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_mem_ctrl.md
SRAM_MEM_CTRL -- requirements
Module: sram_mem_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, 9, SRAM word-address width (512 x 32-bit words).
REQ-002 Parameter: BASE_ADDR, 32'h0000_0000, byte base address of the SRAM window; aligned to 4*2^ADDR_WIDTH.
REQ-003 Port: clk  input  1  single clock; also drives clk0 and clk1.
REQ-004 Port: resetn  input  1  asynchronous, active-low reset.
REQ-005 Port: mem_valid, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]  input  CPU native-bus request; wstrb==0 means read.
REQ-006 Port: mem_ready  output  1; mem_rdata  output  32  CPU completion and read data.
REQ-007 Port: rd_valid  input  1; rd_addr  input  ADDR_WIDTH  secondary read-only requester (word address).
REQ-008 Port: rd_ready  output  1; rd_data  output  32  secondary completion and data.
REQ-009 Port: clk0, csb0, web0, wmask0[3:0], addr0[ADDR_WIDTH-1:0], din0[31:0]  output  SRAM RW-port drive; dout0[31:0]  input.
REQ-010 Port: clk1, csb1, addr1[ADDR_WIDTH-1:0]  output  SRAM R-port drive; dout1[31:0]  input.

Function
REQ-011 CPU request selected when mem_valid=1 and mem_addr[31:ADDR_WIDTH+2] equals BASE_ADDR[31:ADDR_WIDTH+2]; unselected requests are ignored (mem_ready stays 0).
REQ-012 Word address = mem_addr[ADDR_WIDTH+1:2]; mem_addr[1:0] ignored.
REQ-013 Port-0 FSM states: IDLE, ACCESS, CAPTURE, DONE.
REQ-014 IDLE: selected request in cycle N -> register addr0/din0/wmask0/web0 (web0=0 iff wstrb!=0) and enter ACCESS; csb0=0 during cycle N+1 only.
REQ-015 Write: ACCESS -> DONE; mem_ready=1 for exactly cycle N+2.
REQ-016 Read: ACCESS -> CAPTURE; mem_rdata loaded from dout0 at end of cycle N+2; DONE with mem_ready=1 for exactly cycle N+3.
REQ-017 DONE -> IDLE unconditionally; a mem_valid still high in DONE is not re-accepted (new request earliest the cycle after DONE).
REQ-018 mem_rdata holds its last value between reads; unchanged by writes.
REQ-019 csb0=1, csb1=1 in every cycle not explicitly an access cycle; web0=1 whenever csb0=1.
REQ-020 Port-1 FSM (IDLE, ACCESS, CAPTURE): rd_valid in cycle M -> csb1=0 with addr1 in cycle M+1; rd_data loaded from dout1 at end of M+2; rd_ready=1 for exactly M+3; back-to-back accepted from M+4.
REQ-021 Collision: if port-1 ACCESS would coincide with a port-0 write ACCESS to the same word, port 1 SHALL delay its ACCESS by one cycle (rd_ready moves one cycle later); reads never collide.
REQ-022 rd_addr and mem_* are sampled only at acceptance; changes afterward do not affect the transaction.
REQ-023 clk0 and clk1 SHALL be connected directly to clk, no gating.

Reset
REQ-024 resetn low: both FSMs -> IDLE immediately; csb0=1, csb1=1, web0=1, wmask0=0, addr0=0, din0=0, addr1=0, mem_ready=0, rd_ready=0, mem_rdata=0, rd_data=0.
REQ-025 Reset mid-transaction aborts it; no ready pulse is issued for the aborted request after reset release.
REQ-026 First acceptance possible in the first rising edge with resetn high.

Structure
REQ-027 Package sram_ctrl_pkg holds ADDR_WIDTH/DATA_WIDTH/NUM_WMASKS defaults and the port FSM state enumeration.
REQ-028 Port-1 read FSM SHALL be a sub-module sram_rd_port with a collision-stall input; port-0 logic stays in the top.

Verification
REQ-029 Write 32'hDEADBEEF, wstrb=4'hF to BASE_ADDR+0x10 -> csb0=0,web0=0,addr0=4 in N+1; mem_ready in N+2; subsequent read returns 32'hDEADBEEF with mem_ready in N+3.
REQ-030 Byte write wstrb=4'b0100, wdata=32'h00AA0000 over 32'hDEADBEEF -> read returns 32'hDEAABEEF.
REQ-031 Request at BASE_ADDR+0x800 (outside window) held 10 cycles -> csb0 stays 1, mem_ready never asserts.
REQ-032 Port-0 write to word 7 and rd_valid on word 7 same cycle -> port-1 access delayed one cycle, rd_data equals the newly written value, rd_ready at M+4.
REQ-033 Simultaneous CPU read word 3 and port-1 read word 3 -> both complete at N+3/M+3 with identical data.
REQ-034 resetn asserted during CAPTURE -> all outputs at reset values immediately; no mem_ready after release; next request completes normally.
